// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Shared types and widths for the UART command assembler.
//             Holds the framing FSM state type and the byte/command widths.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  // HIGH: waiting for the first (high) byte of a command.
  // LOW : high byte held, waiting for the second (low) byte.
  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler
//  Purpose  : Pairs bytes from a UART receiver, high byte first, into 16-bit
//             commands. An inter-byte timeout drops a lone high byte so that
//             framing resynchronises. A sticky flag reports overwritten commands.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             rx_rdy, rx_data       - byte-available flag and byte from receiver
//             clr_rx_rdy            - consumes the current byte (same cycle)
//             clr_cmd_rdy           - consumer acknowledge of cmd
//             clr_overrun           - clears the overrun flag
//             cmd, cmd_rdy          - assembled command and its valid flag
//             overrun               - sticky: command completed while cmd_rdy=1
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  input  logic              clr_cmd_rdy,
  input  logic              clr_overrun,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              overrun
);

  // A zero TIMEOUT still needs a 1-bit timer to keep the logic well formed.
  localparam int TIMER_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [BYTE_W-1:0]   hi_byte;
  logic [TIMER_W-1:0]  timer;
  logic                take_hi;
  logic                complete;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Mealy handshake. A byte present in LOW is always taken,
  // even when the timer is about to expire: the byte wins.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    clr_rx_rdy = 1'b0;
    take_hi    = 1'b0;
    complete   = 1'b0;
    case (state)
      HIGH: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          take_hi    = 1'b1;
          state_nxt  = LOW;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          complete   = 1'b1;
          state_nxt  = HIGH;
        end else if ((TIMEOUT != 0) && (timer == TIMER_W'(1))) begin
          // Lone high byte is abandoned; cmd/cmd_rdy are left untouched.
          state_nxt = HIGH;
        end
      end
      default: state_nxt = HIGH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: high-byte capture, inter-byte timer, command and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte <= '0;
      timer   <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (take_hi) begin
        hi_byte <= rx_data;
        timer   <= TIMER_W'(TIMEOUT);
      end else if ((state == LOW) && !rx_rdy && (timer != '0)) begin
        // Loaded with TIMEOUT on the capture edge, reaching 1 after
        // TIMEOUT-1 decrements, so expiry lands exactly TIMEOUT edges later.
        timer <= timer - 1'b1;
      end

      if (complete) begin
        cmd <= {hi_byte, rx_data};
      end

      // Completion beats acknowledge.
      if (complete) begin
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      // An acknowledge arriving with the completion means the old command was
      // consumed, so that case is not an overrun.
      if (complete && cmd_rdy && !clr_cmd_rdy) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
